piso_queue_write_scheduler: RTL

Credit-based round-robin scheduler placed in front of the activation-buffer parallel-in/serial-out write queue. It grants up to maxGrantsPerCycle of numRequesters write requesters per cycle, and never grants more than the free queue slots, so no write is ever dropped on full. It tracks queue occupancy from grants and downstream pops, and provides a flush/drain sequence used before layer switches.

---
 rtl/piso_queue_write_scheduler_if.sv | 28 ++
 rtl/piso_queue_write_scheduler.sv | 107 ++++++++++
 2 files changed

// File: rtl/piso_queue_write_scheduler_if.sv
// Handshake bundle between the write requesters, the PISO write queue and the
// credit-based write scheduler.
interface piso_queue_write_scheduler_if #(
  parameter int numRequesters = 8,
  parameter int cntWidth      = 8
);
  logic                     enable;
  logic                     flush_req;
  logic [numRequesters-1:0] req_valid;
  logic [numRequesters-1:0] req_ready;
  logic [numRequesters-1:0] q_valid_in;
  logic                     q_pop;
  logic [cntWidth-1:0]      occupancy;
  logic [cntWidth-1:0]      credits;
  logic                     busy;
  logic                     flush_done;
  logic                     err_underflow;

  modport master (
    output enable, flush_req, req_valid, q_pop,
    input  req_ready, q_valid_in, occupancy, credits, busy, flush_done, err_underflow
  );

  modport slave (
    input  enable, flush_req, req_valid, q_pop,
    output req_ready, q_valid_in, occupancy, credits, busy, flush_done, err_underflow
  );
endinterface

// File: rtl/piso_queue_write_scheduler.sv
// Credit-based round-robin write scheduler in front of the PISO activation queue.
// Grants never exceed free slots; a flush stops granting and waits for the queue to drain.
module piso_queue_write_scheduler #(
  parameter int numRequesters     = 8,
  parameter int queueDepth        = 8,
  parameter int maxGrantsPerCycle = 4,
  parameter int cntWidth          = 8
) (
  input logic                    clk,
  input logic                    nrst,
  piso_queue_write_scheduler_if.slave bus
);
  localparam int PtrW = (numRequesters > 1) ? $clog2(numRequesters) : 1;
  localparam logic [cntWidth-1:0] DepthC = cntWidth'(queueDepth);
  localparam logic [cntWidth-1:0] MaxGC  = cntWidth'(maxGrantsPerCycle);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                   state_q;
  logic [cntWidth-1:0]      occ_q, occ_d;
  logic [cntWidth-1:0]      credits, limit, n_acc;
  logic [PtrW-1:0]          rr_ptr_q, rr_ptr_d, idx;
  logic [numRequesters-1:0] ready;
  logic                     busy_q, flush_done_q, err_q;
  logic                     grant_en, pop_eff;

  assign credits  = DepthC - occ_q;
  assign grant_en = (state_q == RUN) && bus.enable && !bus.flush_req;
  assign pop_eff  = bus.q_pop && (occ_q != '0);

  // Credits are the registered free count; a pop this cycle frees a slot only next cycle.
  always_comb begin
    ready    = '0;
    n_acc    = '0;
    idx      = '0;
    rr_ptr_d = rr_ptr_q;
    limit    = (credits < MaxGC) ? credits : MaxGC;
    if (grant_en) begin
      for (int k = 0; k < numRequesters; k++) begin
        idx = PtrW'((int'(rr_ptr_q) + k) % numRequesters);
        if (bus.req_valid[idx] && (n_acc < limit)) begin
          ready[idx] = 1'b1;
          n_acc      = n_acc + cntWidth'(1);
          rr_ptr_d   = PtrW'((int'(idx) + 1) % numRequesters);
        end
      end
    end
    occ_d = occ_q + n_acc - cntWidth'(pop_eff);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      occ_q        <= '0;
      rr_ptr_q     <= '0;
      busy_q       <= 1'b0;
      flush_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      occ_q        <= occ_d;
      rr_ptr_q     <= rr_ptr_d;
      flush_done_q <= 1'b0;
      if (bus.q_pop && (occ_q == '0)) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (bus.flush_req) begin
            state_q      <= DONE;
            flush_done_q <= 1'b1;
          end else if (bus.enable) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (bus.flush_req) begin
            state_q <= DRAIN;
          end else if (!bus.enable) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        DRAIN: begin
          if (occ_d == '0) begin
            state_q      <= DONE;
            busy_q       <= 1'b0;
            flush_done_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready     = ready;
  assign bus.q_valid_in    = bus.req_valid & ready;
  assign bus.occupancy     = occ_q;
  assign bus.credits       = credits;
  assign bus.busy          = busy_q;
  assign bus.flush_done    = flush_done_q;
  assign bus.err_underflow = err_q;
endmodule
